// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Holds the FSM encoding, iteration count and the Booth digit recoding rule.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_PM   = 3'd1,
    DIG_P2M  = 3'd2,
    DIG_NM   = 3'd3,
    DIG_N2M  = 3'd4
  } digit_t;

  function automatic int unsigned iter_count(input int unsigned width);
    return (width + 2) / 2;
  endfunction

  // Overlapping 3-bit window {q1, q0, guard} to a signed radix-4 digit.
  function automatic digit_t recode(input logic [2:0] window);
    digit_t d;
    case (window)
      3'b001, 3'b010: d = DIG_PM;
      3'b011:         d = DIG_P2M;
      3'b100:         d = DIG_N2M;
      3'b101, 3'b110: d = DIG_NM;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: 3-bit window to negate / 1x / 2x selects.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] i_window,
  output logic       o_neg_c,
  output logic       o_one_c,
  output logic       o_two_c
);

  digit_t w_digit;

  always_comb begin
    w_digit = recode(i_window);
    o_neg_c = 1'b0;
    o_one_c = 1'b0;
    o_two_c = 1'b0;
    case (w_digit)
      DIG_PM:  o_one_c = 1'b1;
      DIG_P2M: o_two_c = 1'b1;
      DIG_NM:  begin o_neg_c = 1'b1; o_one_c = 1'b1; end
      DIG_N2M: begin o_neg_c = 1'b1; o_two_c = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
// Retires two multiplier bits per CALC cycle; product held until the next done.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned ITER = iter_count(WIDTH);
  localparam int unsigned MW   = WIDTH + 2;
  localparam int unsigned HW   = WIDTH + 3;
  localparam int unsigned PW   = HW + MW + 1;
  localparam int unsigned CW   = $clog2(ITER);
  localparam int unsigned RW   = 2 * WIDTH;

  state_t         r_state;
  state_t         w_next_state;
  logic [CW-1:0]  r_cnt;
  logic [MW-1:0]  r_m;
  logic [PW-1:0]  r_p;
  logic           r_busy;
  logic           r_done;
  logic [RW-1:0]  r_product;

  logic           w_load;
  logic           w_step;
  logic           w_finish;
  logic           w_neg;
  logic           w_one;
  logic           w_two;
  logic [MW-1:0]  w_a_ext;
  logic [MW-1:0]  w_b_ext;
  logic [HW-1:0]  w_m_ext;
  logic [HW-1:0]  w_addend;
  logic [HW-1:0]  w_hi_sum;
  logic [PW-1:0]  w_p_sum;
  logic [PW-1:0]  w_p_shift;

  assign w_a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign w_b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == CW'(ITER - 1)) w_next_state = DONE;
      end
      DONE: begin
        w_finish     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  booth_r4_recoder u_recoder (
    .i_window (r_p[2:0]),
    .o_neg_c  (w_neg),
    .o_one_c  (w_one),
    .o_two_c  (w_two)
  );

  // Add the recoded digit into the high part, then arithmetic shift by two.
  always_comb begin
    w_m_ext  = {r_m[MW-1], r_m};
    w_addend = '0;
    if (w_two)      w_addend = w_m_ext << 1;
    else if (w_one) w_addend = w_m_ext;
    if (w_neg)      w_addend = ~w_addend + HW'(1);
    w_hi_sum  = r_p[PW-1 -: HW] + w_addend;
    w_p_sum   = {w_hi_sum, r_p[PW-HW-1:0]};
    w_p_shift = PW'($signed(w_p_sum) >>> 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_m       <= '0;
      r_p       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_busy <= (w_next_state != IDLE);
      r_done <= w_finish;
      if (w_finish) r_product <= r_p[RW:1];
      if (w_load) begin
        r_m   <= w_a_ext;
        r_p   <= {HW'(0), w_b_ext, 1'b0};
        r_cnt <= '0;
      end else if (w_step) begin
        r_p   <= w_p_shift;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4 at WIDTH=16 and WIDTH=8.
// Products are compared against plain integer multiplication of the extended operands.
module tb_booth_mult_r4;

  localparam int ITER16 = (16 + 2) / 2;
  localparam int ITER8  = (8 + 2) / 2;

  logic        clk;
  logic        rst;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int n_checks;
  int n_pass;

  booth_mult_r4 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
  );

  booth_mult_r4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint ref_mult(input longint x, input longint y, input logic sm, input int w);
    longint sx, sy, p;
    sx = x;
    sy = y;
    if (sm && x[w-1]) sx = x - (longint'(1) << w);
    if (sm && y[w-1]) sy = y - (longint'(1) << w);
    p = sx * sy;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       output logic [31:0] prod, output int lat);
    int cnt;
    @(posedge clk); #1;
    a16 = ta; b16 = tb_; sm16 = ts; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (done16) break;
    end
    if (done16) begin lat = cnt; prod = prod16; end
    else begin lat = -1; prod = '0; end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                      output logic [15:0] prod, output int lat);
    int cnt;
    @(posedge clk); #1;
    a8 = ta; b8 = tb_; sm8 = ts; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (done8) break;
    end
    if (done8) begin lat = cnt; prod = prod8; end
    else begin lat = -1; prod = '0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy16, done16, prod16} !== 34'd0)
      $display("FAIL reset16: busy=%0b done=%0b product=%h, need all zero", busy16, done16, prod16);
    else n_pass++;
    n_checks++;
    if ({busy8, done8, prod8} !== 18'd0)
      $display("FAIL reset8: busy=%0b done=%0b product=%h, need all zero", busy8, done8, prod8);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] av [7] = '{16'd3, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic [15:0] bv [7] = '{16'd5, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000};
    logic        sv [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ev [7] = '{32'h0000000F, 32'h40000000, 32'h40000000, 32'hFFFFFFFF,
                            32'h0000FFFF, 32'hFFFE0001, 32'hC0008000};
    logic [31:0] p;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run16(av[i], bv[i], sv[i], p, lat);
      n_checks++;
      if (p !== ev[i] || lat != ITER16 + 1)
        $display("FAIL directed[%0d]: product=%h latency=%0d, need %h latency %0d",
                 i, p, lat, ev[i], ITER16 + 1);
      else n_pass++;
    end
  endtask

  task automatic test_random16();
    logic [15:0] ta, tb_;
    logic        ts;
    logic [31:0] p, e;
    int lat;
    for (int i = 0; i < 200; i++) begin
      ta = 16'($urandom); tb_ = 16'($urandom); ts = 1'($urandom);
      e = 32'(ref_mult(longint'(ta), longint'(tb_), ts, 16));
      run16(ta, tb_, ts, p, lat);
      n_checks++;
      if (p !== e || lat != ITER16 + 1)
        $display("FAIL random16 %h*%h s=%0b: product=%h latency=%0d, need %h latency %0d",
                 ta, tb_, ts, p, lat, e, ITER16 + 1);
      else n_pass++;
    end
  endtask

  task automatic test_busy_start();
    int cnt, ndone, first;
    logic [31:0] p;
    @(posedge clk); #1;
    a16 = 16'd7; b16 = 16'd9; sm16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cnt = 0; ndone = 0; first = -1; p = '0;
    while (cnt < 30) begin
      if (cnt == 3) begin a16 = 16'd2; b16 = 16'd2; start16 = 1'b1; end
      else start16 = 1'b0;
      @(posedge clk); #1;
      cnt++;
      if (cnt == 3) begin
        n_checks++;
        if (busy16 !== 1'b1) $display("FAIL busy_during_calc: busy=%0b, need 1", busy16);
        else n_pass++;
      end
      if (done16) begin
        ndone++;
        if (first < 0) begin first = cnt; p = prod16; end
      end
    end
    start16 = 1'b0;
    n_checks++;
    if (ndone != 1 || first != ITER16 + 1 || p !== 32'h0000003F)
      $display("FAIL busy_start_ignored: dones=%0d first=%0d product=%h, need 1 done at %0d product 0000003f",
               ndone, first, p, ITER16 + 1);
    else n_pass++;
  endtask

  task automatic test_operand_change();
    logic [15:0] ta, tb_;
    logic        ts;
    logic [31:0] e;
    int cnt;
    for (int i = 0; i < 20; i++) begin
      ta = 16'($urandom); tb_ = 16'($urandom); ts = 1'($urandom);
      e = 32'(ref_mult(longint'(ta), longint'(tb_), ts, 16));
      @(posedge clk); #1;
      a16 = ta; b16 = tb_; sm16 = ts; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      cnt = 0;
      while (cnt < 40) begin
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
        @(posedge clk); #1;
        cnt++;
        if (done16) break;
      end
      n_checks++;
      if (!done16 || prod16 !== e)
        $display("FAIL operand_change %h*%h s=%0b: done=%0b product=%h, need %h",
                 ta, tb_, ts, done16, prod16, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int cnt;
    @(posedge clk); #1;
    a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom); start16 = 1'b1;
    e = 32'(ref_mult(longint'(a16), longint'(b16), sm16, 16));
    for (int i = 0; i < 8; i++) begin
      cnt = 0;
      while (cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
        if (done16) break;
      end
      n_checks++;
      if (!done16 || prod16 !== e || cnt != ITER16 + 2 || busy16 !== 1'b0)
        $display("FAIL back_to_back[%0d]: done=%0b product=%h gap=%0d busy=%0b, need %h gap %0d busy 0",
                 i, done16, prod16, cnt, busy16, e, ITER16 + 2);
      else n_pass++;
      if (i == 7) start16 = 1'b0;
      else begin
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
        e = 32'(ref_mult(longint'(a16), longint'(b16), sm16, 16));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    int lat, seen;
    run16(16'd3, 16'd5, 1'b1, p, lat);
    n_checks++;
    if (p !== 32'h0000000F) $display("FAIL pre_abort: product=%h, need 0000000f", p);
    else n_pass++;
    @(posedge clk); #1;
    a16 = 16'd100; b16 = 16'd200; sm16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'd0)
      $display("FAIL abort: busy=%0b done=%0b product=%h, need 0 0 00000000", busy16, done16, prod16);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done16 || busy16) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL abort_no_done: activity cycles=%0d, need 0", seen);
    else n_pass++;
    run16(16'd6, 16'd7, 1'b1, p, lat);
    n_checks++;
    if (p !== 32'h0000002A || lat != ITER16 + 1)
      $display("FAIL after_abort: product=%h latency=%0d, need 0000002a latency %0d", p, lat, ITER16 + 1);
    else n_pass++;
  endtask

  task automatic test_width8();
    logic [7:0]  cv [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    logic [7:0]  ta, tb_;
    logic        ts;
    logic [15:0] p, e;
    int lat;
    for (int i = 0; i < 1050; i++) begin
      if (i < 50) begin
        ta = cv[(i / 2) % 5]; tb_ = cv[(i / 10) % 5]; ts = 1'(i % 2);
      end else begin
        ta = 8'($urandom); tb_ = 8'($urandom); ts = 1'($urandom);
      end
      e = 16'(ref_mult(longint'(ta), longint'(tb_), ts, 8));
      run8(ta, tb_, ts, p, lat);
      n_checks++;
      if (p !== e || lat != ITER8 + 1)
        $display("FAIL width8 %h*%h s=%0b: product=%h latency=%0d, need %h latency %0d",
                 ta, tb_, ts, p, lat, e, ITER8 + 1);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    test_reset();
    test_directed();
    test_random16();
    test_busy_start();
    test_operand_change();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
